jump_ctrl_seq: RTL and testbench

Hardwired control-step sequencer for the Mini SRC datapath. It drives the fetch steps and the execute steps for the jump/branch class (`jal`, `jr`, `br`) directly into the `Datapath` control inputs, replacing hand-sequenced testbench stimulus. It generalises the fixed T0–T4 `jal` sequence in three ways:
- a configurable memory wait-state count;
- a configurable link register;
- a run/done handshake for back-to-back instructions.

---
 rtl/jump_ctrl_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_jump_ctrl_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl_seq.sv
// jump_ctrl_seq -- hardwired control-step sequencer for the Mini SRC datapath.
//
// Drives the instruction fetch (T0..T2) and the execute steps of the jump/branch
// class (jal, jr, br) straight into the Datapath control inputs.
//
// Build option:
//   SEQ_HALT_EN  when defined, the halt opcode parks the machine in HALT (step=8)
//                until clr; when undefined, halt is decoded as an illegal opcode
//                and the HALT state does not exist.
//
// Parameters:
//   WIDTH     IR width; opcode = ir[WIDTH-1 -: 5], Ra = ir[WIDTH-6 -: 4]
//   MEM_WAIT  extra cycles T1 is held for the RAM read (0..15)
//   LINK_REG  register index written by jal
//
// Ports:
//   clk       rising-edge clock
//   clr       synchronous active-high reset
//   run       permit start of next instruction (sampled in IDLE and final steps)
//   ir        instruction register contents (IRdataout), sampled only in T3
//   con_ff    branch condition flop output, sampled only in T6
//   PCout .. Zlowout  datapath control strobes
//   link_in   write enable for register LINK_REG
//   link_sel  constant LINK_REG
//   step      current state encoding
//   done      one-cycle pulse in the final step of an instruction
//   illegal   one-cycle pulse when a non-jump opcode is decoded
module jump_ctrl_seq #(
  parameter int WIDTH    = 32,
  parameter int MEM_WAIT = 0,
  parameter int LINK_REG = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [WIDTH-1:0] ir,
  input  logic             con_ff,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             PCin,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             Yin,
  output logic             Cout,
  output logic             Zin,
  output logic             Zlowout,
  output logic             link_in,
  output logic [3:0]       link_sel,
  output logic [3:0]       step,
  output logic             done,
  output logic             illegal
);

  if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("jump_ctrl_seq: MEM_WAIT must be in 0..15");
  end

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7
`ifdef SEQ_HALT_EN
    ,
    S_HALT = 4'd8
`endif
  } state_t;

  // Instruction kind remembered past T3 so later steps never look at ir again.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_JAL  = 2'd1,
    K_BR   = 2'd2
  } kind_t;

  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
`ifdef SEQ_HALT_EN
  localparam logic [4:0] OP_HALT = 5'b11010;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  kind_t      kind;
  logic [3:0] wcnt;
  logic [4:0] opcode;

  assign opcode = ir[WIDTH-1 -: 5];

  // Register fields are selected inside the datapath via Gra, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[WIDTH-6:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      kind  <= K_NONE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0: begin
          state <= S_T1;
          wcnt  <= '0;
        end
        S_T1: begin
          if (wcnt == WAIT_LAST) begin
            state <= S_T2;
          end else if (wcnt != 4'hF) begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_T2: state <= S_T3;
        S_T3: begin
          case (opcode)
            OP_JAL: begin
              kind  <= K_JAL;
              state <= S_T4;
            end
            OP_BR: begin
              kind  <= K_BR;
              state <= S_T4;
            end
`ifdef SEQ_HALT_EN
            OP_HALT: state <= S_HALT;
`endif
            // jr completes here; anything else is illegal and also ends here.
            default: state <= run ? S_T0 : S_IDLE;
          endcase
        end
        S_T4: begin
          if (kind == K_BR) state <= S_T5;
          else              state <= run ? S_T0 : S_IDLE;
        end
        S_T5: state <= S_T6;
        S_T6: state <= run ? S_T0 : S_IDLE;
`ifdef SEQ_HALT_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes follow the state register; T3 additionally decodes the freshly
  // loaded IR, and T6 gates PCin with the branch condition.
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    PCin    = 1'b0;
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    link_in = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        IncPC = (wcnt == 4'd0);
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (opcode)
          OP_JR: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
            done = 1'b1;
          end
          OP_JAL: begin
            PCout   = 1'b1;
            link_in = 1'b1;
          end
          OP_BR: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            CONin = 1'b1;
          end
`ifdef SEQ_HALT_EN
          OP_HALT: ;
`endif
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        if (kind == K_JAL) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          PCin = 1'b1;
          done = 1'b1;
        end else begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
      end
      S_T5: begin
        Cout = 1'b1;
        Zin  = 1'b1;
      end
      S_T6: begin
        Zlowout = 1'b1;
        PCin    = con_ff;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign step     = state;
  assign link_sel = 4'(LINK_REG);

endmodule

// File: tb/tb_jump_ctrl_seq.sv
// Directed bench for jump_ctrl_seq. Three sequencers (MEM_WAIT 0, 2, 3) share a
// small behavioural Mini SRC datapath; the selected one drives it, the others
// are held in clr.
module tb_jump_ctrl_seq;

  // Strobe word bit positions
  localparam logic [17:0] B_PCOUT = 18'h20000;
  localparam logic [17:0] B_MARIN = 18'h10000;
  localparam logic [17:0] B_INCPC = 18'h08000;
  localparam logic [17:0] B_READ  = 18'h04000;
  localparam logic [17:0] B_MDRIN = 18'h02000;
  localparam logic [17:0] B_MDROUT= 18'h01000;
  localparam logic [17:0] B_IRIN  = 18'h00800;
  localparam logic [17:0] B_PCIN  = 18'h00400;
  localparam logic [17:0] B_GRA   = 18'h00200;
  localparam logic [17:0] B_ROUT  = 18'h00100;
  localparam logic [17:0] B_CONIN = 18'h00080;
  localparam logic [17:0] B_YIN   = 18'h00040;
  localparam logic [17:0] B_COUT  = 18'h00020;
  localparam logic [17:0] B_ZIN   = 18'h00010;
  localparam logic [17:0] B_ZLOW  = 18'h00008;
  localparam logic [17:0] B_LINK  = 18'h00004;
  localparam logic [17:0] B_DONE  = 18'h00002;
  localparam logic [17:0] B_ILL   = 18'h00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        clr_v;
  logic              run;
  logic [1:0]        sel;
  logic [2:0][17:0]  sv;
  logic [2:0][3:0]   st;
  logic [2:0][3:0]   ls;

  // Datapath model state
  logic [31:0] pc, mar, mdr, ir_q, y, z, bus;
  logic        con;
  logic [31:0] rf [16];
  logic [31:0] mem [64];
  logic        preset;
  logic [31:0] pre_pc, pre_r6;

  logic [17:0] cur;
  logic [3:0]  cur_step;
  logic [3:0]  cur_lsel;
  assign cur      = sv[sel];
  assign cur_step = st[sel];
  assign cur_lsel = ls[sel];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jump_ctrl_seq #(
      .WIDTH(32),
      .MEM_WAIT((g == 0) ? 0 : (g == 1) ? 2 : 3),
      .LINK_REG(15)
    ) dut (
      .clk(clk), .clr(clr_v[g]), .run(run), .ir(ir_q), .con_ff(con),
      .PCout(sv[g][17]), .MARin(sv[g][16]), .IncPC(sv[g][15]), .Read(sv[g][14]),
      .MDRin(sv[g][13]), .MDRout(sv[g][12]), .IRin(sv[g][11]), .PCin(sv[g][10]),
      .Gra(sv[g][9]), .Rout(sv[g][8]), .CONin(sv[g][7]), .Yin(sv[g][6]),
      .Cout(sv[g][5]), .Zin(sv[g][4]), .Zlowout(sv[g][3]), .link_in(sv[g][2]),
      .link_sel(ls[g]), .step(st[g]), .done(sv[g][1]), .illegal(sv[g][0])
    );
  end

  always_comb begin
    bus = '0;
    if ((cur & B_PCOUT) != 0)  bus = pc;
    if ((cur & B_MDROUT) != 0) bus = mdr;
    if ((cur & B_ROUT) != 0)   bus = rf[ir_q[26:23]];
    if ((cur & B_COUT) != 0)   bus = {{13{ir_q[18]}}, ir_q[18:0]};
    if ((cur & B_ZLOW) != 0)   bus = z;
  end

  always @(posedge clk) begin
    if (preset) begin
      pc     <= pre_pc;
      rf[2]  <= 32'hFFFFDEBD;
      rf[6]  <= pre_r6;
      rf[15] <= '0;
      ir_q   <= '0;
      con    <= 1'b0;
    end else begin
      if ((cur & B_MARIN) != 0) mar <= bus;
      if ((cur & B_READ) != 0 && (cur & B_MDRIN) != 0) mdr <= mem[mar[5:0]];
      if ((cur & B_INCPC) != 0) pc <= pc + 32'd1;
      if ((cur & B_PCIN) != 0)  pc <= bus;
      if ((cur & B_IRIN) != 0)  ir_q <= bus;
      if ((cur & B_LINK) != 0)  rf[cur_lsel] <= bus;
      if ((cur & B_YIN) != 0)   y <= bus;
      if ((cur & B_ZIN) != 0)   z <= y + bus;
      if ((cur & B_CONIN) != 0) begin
        case (ir_q[20:19])
          2'd0: con <= (bus == 0);
          2'd1: con <= (bus != 0);
          2'd2: con <= ~bus[31];
          default: con <= bus[31];
        endcase
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] seen [9];

  // Reset everything, preload the datapath, then release sequencer idx with
  // run=1 so the bench returns in T0 (cycle 1).
  task automatic launch(input logic [1:0] idx, input logic [31:0] pc0,
                        input logic [31:0] instr, input logic [31:0] r6);
    mem[pc0[5:0]] = instr;
    pre_pc = pc0;
    pre_r6 = r6;
    sel    = idx;
    clr_v  = 3'b111;
    run    = 1'b0;
    preset = 1'b1;
    tick();
    preset = 1'b0;
    clr_v[idx] = 1'b0;
    run = 1'b1;
    tick();
  endtask

  // Runs one instruction from T0 until done/illegal/HALT (bounded), then takes
  // one more edge with run=run_next.
  task automatic exec_instr(input logic [1:0] idx, input logic [31:0] pc0,
                            input logic [31:0] instr, input logic [31:0] r6,
                            input logic run_next,
                            output int cyc, output int incn, output int t1n,
                            output logic pcin6, output logic [3:0] post_step);
    for (int i = 0; i < 9; i++) seen[i] = '0;
    incn  = 0;
    t1n   = 0;
    pcin6 = 1'b0;
    launch(idx, pc0, instr, r6);
    cyc = 1;
    while (1) begin
      if (cur_step < 9) seen[cur_step] = cur;
      if ((cur & B_INCPC) != 0) incn++;
      if (cur_step == 4'd2) t1n++;
      if (cur_step == 4'd7) pcin6 = ((cur & B_PCIN) != 0);
      if ((cur & (B_DONE | B_ILL)) != 0 || cur_step == 4'd8 || cyc >= 30) break;
      tick();
      cyc++;
    end
    run = run_next;
    tick();
    post_step = cur_step;
  endtask

  int          cyc, incn, t1n, n;
  logic        pcin6;
  logic [3:0]  post;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    sel    = 2'd0;
    clr_v  = 3'b111;
    run    = 1'b1;
    preset = 1'b1;
    pre_pc = 32'd0;
    pre_r6 = 32'd0;
    tick();
    tick();

    // Reset state
    check("reset_step", 32'(cur_step), 32'd0);
    check("reset_strobes", 32'(cur), 32'd0);
    check("reset_link_sel", 32'(cur_lsel), 32'd15);

    // jal R2, MEM_WAIT=0, PC=14
    exec_instr(2'd0, 32'd14, 32'hA1000000, 32'd0, 1'b1, cyc, incn, t1n, pcin6, post);
    check("jal_done_cycle", 32'(cyc), 32'd5);
    check("jal_t0", 32'(seen[1]), 32'(B_PCOUT | B_MARIN));
    check("jal_t1", 32'(seen[2]), 32'(B_READ | B_MDRIN | B_INCPC));
    check("jal_t2", 32'(seen[3]), 32'(B_MDROUT | B_IRIN));
    check("jal_t3", 32'(seen[4]), 32'(B_PCOUT | B_LINK));
    check("jal_t4", 32'(seen[5]), 32'(B_GRA | B_ROUT | B_PCIN | B_DONE));
    check("jal_next_t0", 32'(post), 32'd1);
    check("jal_r15", rf[15], 32'd15);
    check("jal_pc", pc, 32'hFFFFDEBD);

    // jr R2, MEM_WAIT=2
    exec_instr(2'd1, 32'd14, 32'h99000000, 32'd0, 1'b0, cyc, incn, t1n, pcin6, post);
    check("jr_done_cycle", 32'(cyc), 32'd6);
    check("jr_t1_cycles", 32'(t1n), 32'd3);
    check("jr_incpc_count", 32'(incn), 32'd1);
    check("jr_t3", 32'(seen[4]), 32'(B_GRA | B_ROUT | B_PCIN | B_DONE));
    check("jr_pc", pc, 32'hFFFFDEBD);
    check("jr_idle_after", 32'(post), 32'd0);

    // brzr R6,25 taken
    exec_instr(2'd0, 32'd14, 32'h93000019, 32'd0, 1'b0, cyc, incn, t1n, pcin6, post);
    check("br_taken_done_cycle", 32'(cyc), 32'd7);
    check("br_t3", 32'(seen[4]), 32'(B_GRA | B_ROUT | B_CONIN));
    check("br_t4", 32'(seen[5]), 32'(B_PCOUT | B_YIN));
    check("br_t5", 32'(seen[6]), 32'(B_COUT | B_ZIN));
    check("br_taken_t6", 32'(seen[7]), 32'(B_ZLOW | B_DONE | B_PCIN));
    check("br_taken_pcin", 32'(pcin6), 32'd1);
    check("br_taken_pc", pc, 32'd40);

    // brzr R6,25 not taken
    exec_instr(2'd0, 32'd14, 32'h93000019, 32'd5, 1'b0, cyc, incn, t1n, pcin6, post);
    check("br_nt_done_cycle", 32'(cyc), 32'd7);
    check("br_nt_t6", 32'(seen[7]), 32'(B_ZLOW | B_DONE));
    check("br_nt_pc", pc, 32'd15);

    // add: illegal
    exec_instr(2'd0, 32'd14, 32'h18000000, 32'd0, 1'b0, cyc, incn, t1n, pcin6, post);
    check("ill_cycle", 32'(cyc), 32'd4);
    check("ill_t3", 32'(seen[4]), 32'(B_ILL));
    check("ill_idle_step", 32'(post), 32'd0);
    check("ill_idle_strobes", 32'(cur), 32'd0);

    // clr during the second T1 cycle, MEM_WAIT=3
    launch(2'd2, 32'd14, 32'h99000000, 32'd0);
    tick();
    check("clr_t1_first_incpc", 32'(cur & B_INCPC), 32'(B_INCPC));
    tick();
    check("clr_t1_second_step", 32'(cur_step), 32'd2);
    check("clr_t1_second_incpc", 32'(cur & B_INCPC), 32'd0);
    clr_v[2] = 1'b1;
    tick();
    check("clr_step", 32'(cur_step), 32'd0);
    check("clr_strobes", 32'(cur), 32'd0);
    check("clr_link_sel", 32'(cur_lsel), 32'd15);
    clr_v[2] = 1'b0;
    run = 1'b1;
    tick();
    check("restart_t0", 32'(cur), 32'(B_PCOUT | B_MARIN));
    tick();
    n = 0;
    incn = 0;
    while (cur_step == 4'd2 && n < 20) begin
      if ((cur & B_INCPC) != 0) incn++;
      n++;
      tick();
    end
    check("restart_t1_cycles", 32'(n), 32'd4);
    check("restart_incpc", 32'(incn), 32'd1);
    check("restart_t2", 32'(cur_step), 32'd3);

    // halt opcode
`ifdef SEQ_HALT_EN
    exec_instr(2'd0, 32'd14, 32'hD0000000, 32'd0, 1'b1, cyc, incn, t1n, pcin6, post);
    check("halt_step", 32'(post), 32'd8);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (cur_step == 4'd8 && cur == '0) n++;
      tick();
    end
    check("halt_held", 32'(n), 32'd20);
    clr_v[0] = 1'b1;
    run = 1'b0;
    tick();
    check("halt_clr_step", 32'(cur_step), 32'd0);
`else
    exec_instr(2'd0, 32'd14, 32'hD0000000, 32'd0, 1'b1, cyc, incn, t1n, pcin6, post);
    check("halt_ill_cycle", 32'(cyc), 32'd4);
    check("halt_ill_t3", 32'(seen[4]), 32'(B_ILL));
    check("halt_ill_next_t0", 32'(post), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
